// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operand request handshake on one side,
// registered result handshake on the other, plus the multiply-busy flag.
interface alu_seq_if #(
   parameter int WIDTH = 32
);
   logic             in_valid_i;
   logic             in_ready_o;
   logic [WIDTH-1:0] data1_i;
   logic [WIDTH-1:0] data2_i;
   logic [2:0]       ALUCtrl_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [WIDTH-1:0] data_o;
   logic             Zero_o;
   logic             busy_o;

   modport master (
      output in_valid_i, data1_i, data2_i, ALUCtrl_i, out_ready_i,
      input  in_ready_o, out_valid_o, data_o, Zero_o, busy_o
   );

   modport slave (
      input  in_valid_i, data1_i, data2_i, ALUCtrl_i, out_ready_i,
      output in_ready_o, out_valid_o, data_o, Zero_o, busy_o
   );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU with a registered result and an iterative shift-add multiplier
// consuming MUL_STEP multiplier bits per cycle.
module alu_seq #(
   parameter int WIDTH    = 32,
   parameter int MUL_STEP = 1
) (
   input  logic     clk_i,
   input  logic     rst_n_i,
   alu_seq_if.slave bus
);
   localparam int N  = WIDTH / MUL_STEP;
   localparam int CW = $clog2(N + 1);

   localparam logic [2:0] OP_SUM = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;

   typedef enum logic {IDLE, MUL} state_t;

   state_t           state_reg, state_next;
   logic [CW-1:0]    count_reg;
   logic [WIDTH-1:0] acc_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] data_reg;
   logic             eq_reg;
   logic             zero_reg;
   logic             out_valid_reg;

   logic             in_ready;
   logic             busy;
   logic             accept;
   logic             accept_mul;
   logic             last_step;
   logic [WIDTH-1:0] alu_result;
   logic [WIDTH-1:0] step_sum;
   logic [WIDTH-1:0] partial [MUL_STEP];

   assign accept     = bus.in_valid_i && in_ready;
   assign accept_mul = accept && (bus.ALUCtrl_i == OP_MUL);
   assign last_step  = (count_reg == CW'(1));

   always_comb begin
      alu_result = bus.data1_i;
      case (bus.ALUCtrl_i)
         OP_SUM:  alu_result = bus.data1_i + bus.data2_i;
         OP_SUB:  alu_result = bus.data1_i - bus.data2_i;
         OP_AND:  alu_result = bus.data1_i & bus.data2_i;
         OP_OR:   alu_result = bus.data1_i | bus.data2_i;
         OP_XOR:  alu_result = bus.data1_i ^ bus.data2_i;
         default: alu_result = bus.data1_i;
      endcase
   end

   // a_reg already carries the shift of all previously consumed steps, so each
   // partial product only needs the in-step bit offset gi.
   for (genvar gi = 0; gi < MUL_STEP; gi++) begin : g_pp
      assign partial[gi] = b_reg[gi] ? (a_reg << gi) : '0;
   end

   always_comb begin
      step_sum = acc_reg;
      for (int i = 0; i < MUL_STEP; i++) begin
         step_sum = step_sum + partial[i];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept_mul) state_next = MUL;
         MUL:     if (last_step)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state_reg == MUL);
      in_ready = (state_reg == IDLE) && (!out_valid_reg || bus.out_ready_i);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         count_reg     <= '0;
         acc_reg       <= '0;
         a_reg         <= '0;
         b_reg         <= '0;
         eq_reg        <= 1'b0;
         data_reg      <= '0;
         zero_reg      <= 1'b0;
         out_valid_reg <= 1'b0;
      end else if (state_reg == MUL) begin
         acc_reg   <= step_sum;
         a_reg     <= a_reg << MUL_STEP;
         b_reg     <= b_reg >> MUL_STEP;
         count_reg <= count_reg - CW'(1);
         if (last_step) begin
            data_reg      <= step_sum;
            zero_reg      <= eq_reg;
            out_valid_reg <= 1'b1;
         end
      end else if (accept) begin
         eq_reg <= (bus.data1_i == bus.data2_i);
         if (accept_mul) begin
            // The output register is emptied here, so completion never collides
            // with a held result.
            a_reg         <= bus.data1_i;
            b_reg         <= bus.data2_i;
            acc_reg       <= '0;
            count_reg     <= CW'(N);
            out_valid_reg <= 1'b0;
         end else begin
            data_reg      <= alu_result;
            zero_reg      <= (bus.data1_i == bus.data2_i);
            out_valid_reg <= 1'b1;
         end
      end else if (bus.out_ready_i) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign bus.in_ready_o  = in_ready;
   assign bus.out_valid_o = out_valid_reg;
   assign bus.data_o      = data_reg;
   assign bus.Zero_o      = zero_reg;
   assign bus.busy_o      = busy;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_alu_seq;
   localparam int N  = 32;
   localparam int N4 = 8;

   localparam logic [2:0] OP_PASS = 3'b000;
   localparam logic [2:0] OP_SUM  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_AND  = 3'b011;
   localparam logic [2:0] OP_OR   = 3'b100;
   localparam logic [2:0] OP_XOR  = 3'b101;
   localparam logic [2:0] OP_MUL  = 3'b110;
   localparam logic [2:0] OP_P7   = 3'b111;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(32)) bus ();
   alu_seq_if #(.WIDTH(32)) bus4 ();

   alu_seq #(.WIDTH(32), .MUL_STEP(1)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus.slave)
   );

   alu_seq #(.WIDTH(32), .MUL_STEP(4)) dut4 (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus4.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int n_txn    = 0;

   // Reference model state: what the consumer should see, and how many more
   // cycles a multiply stays in flight.
   bit          m_valid;
   logic [31:0] m_data;
   bit          m_zero;
   int          m_busy_left;
   logic [31:0] m_pend_data;
   bit          m_pend_zero;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      case (op)
         OP_SUM:  r = a + b;
         OP_SUB:  r = a - b;
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_MUL:  r = a * b;
         default: r = a;
      endcase
      return r;
   endfunction

   // One clock cycle, entered and left at a falling edge: apply inputs, check
   // the outputs of this cycle against the model, then advance the model.
   task automatic step(input bit rst_v, input bit v, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b, input bit rdy);
      bit exp_ready;
      bit acc;
      rst_n           = rst_v;
      bus.in_valid_i  = v;
      bus.ALUCtrl_i   = op;
      bus.data1_i     = a;
      bus.data2_i     = b;
      bus.out_ready_i = rdy;
      #1;
      exp_ready = (m_busy_left == 0) && (!m_valid || rdy);
      check("out_valid", bus.out_valid_o, m_valid);
      check("busy", bus.busy_o, m_busy_left != 0);
      check("in_ready", bus.in_ready_o, exp_ready);
      if (m_valid) begin
         check("data", bus.data_o, m_data);
         check("zero", bus.Zero_o, m_zero);
         if (rdy) begin
            n_txn++;
            $display("txn %0d result data=%08h zero=%0b", n_txn, bus.data_o, bus.Zero_o);
         end
      end
      acc = rst_v && v && exp_ready;
      if (!rst_v) begin
         m_valid = 0; m_data = '0; m_zero = 0; m_busy_left = 0;
      end else if (m_busy_left != 0) begin
         m_busy_left--;
         if (m_busy_left == 0) begin
            m_valid = 1; m_data = m_pend_data; m_zero = m_pend_zero;
         end
      end else if (acc && op == OP_MUL) begin
         m_busy_left = N;
         m_pend_data = ref_op(op, a, b);
         m_pend_zero = (a == b);
         m_valid     = 0;
      end else if (acc) begin
         m_valid = 1; m_data = ref_op(op, a, b); m_zero = (a == b);
      end else if (rdy) begin
         m_valid = 0;
      end
      @(negedge clk);
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(1, 0, OP_PASS, $urandom, $urandom, 1);
   endtask

   task automatic mul4(input logic [31:0] a, input logic [31:0] b);
      int lat;
      bus4.in_valid_i = 1; bus4.ALUCtrl_i = OP_MUL; bus4.data1_i = a; bus4.data2_i = b;
      bus4.out_ready_i = 1;
      @(negedge clk);
      bus4.in_valid_i = 0; bus4.data1_i = $urandom; bus4.data2_i = $urandom;
      lat = 1;
      while (!bus4.out_valid_o && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      check("mul4_latency", lat, N4 + 1);
      check("mul4_data", bus4.data_o, ref_op(OP_MUL, a, b));
      check("mul4_zero", bus4.Zero_o, a == b);
      n_txn++;
      $display("txn %0d mul4 a=%08h b=%08h data=%08h latency=%0d", n_txn, a, b, bus4.data_o, lat);
      @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int busy_cnt;
      logic [31:0] ra, rb;

      rst_n = 0;
      bus.in_valid_i = 0; bus.ALUCtrl_i = OP_PASS; bus.data1_i = '0; bus.data2_i = '0; bus.out_ready_i = 1;
      bus4.in_valid_i = 0; bus4.ALUCtrl_i = OP_PASS; bus4.data1_i = '0; bus4.data2_i = '0; bus4.out_ready_i = 1;
      m_valid = 0; m_data = '0; m_zero = 0; m_busy_left = 0; m_pend_data = '0; m_pend_zero = 0;
      repeat (2) @(negedge clk);

      // Requests during reset must be ignored.
      step(0, 1, OP_SUM, 32'h1, 32'h1, 1);
      step(0, 1, OP_SUM, 32'h1, 32'h1, 1);
      check("rst_data", bus.data_o, 0);
      check("rst_zero", bus.Zero_o, 0);
      check("rst_ready", bus.in_ready_o, 1);

      step(1, 1, OP_SUM, 32'hFFFF_FFFF, 32'h2, 1);
      check("sum_wrap_data", bus.data_o, 32'h1);
      check("sum_wrap_valid", bus.out_valid_o, 1);

      step(1, 1, OP_SUB, 32'd5, 32'd5, 1);
      check("sub_data", bus.data_o, 0);
      check("sub_zero", bus.Zero_o, 1);
      step(1, 1, OP_AND, 32'hF0F0, 32'h0FF0, 1);
      check("and_data", bus.data_o, 32'h00F0);
      check("and_zero", bus.Zero_o, 0);
      step(1, 1, OP_XOR, 32'd3, 32'd3, 1);
      check("xor_data", bus.data_o, 0);
      check("xor_zero", bus.Zero_o, 1);

      step(1, 1, OP_MUL, 32'h0001_0003, 32'h0002_0005, 1);
      lat = 1; busy_cnt = 0;
      while (!bus.out_valid_o && lat < 60) begin
         if (bus.busy_o) busy_cnt++;
         step(1, 0, OP_PASS, $urandom, $urandom, 1);
         lat++;
      end
      check("mul_latency", lat, N + 1);
      check("mul_busy_cycles", busy_cnt, N);
      check("mul_data", bus.data_o, 32'h000B_000F);

      idle(1);
      step(1, 1, OP_OR, 32'h1, 32'h2, 0);
      for (int i = 0; i < 5; i++) begin
         step(1, 1, OP_AND, 32'hFF, 32'h0F, 0);
         check("bp_hold_data", bus.data_o, 32'h3);
      end
      step(1, 1, OP_AND, 32'hFF, 32'h0F, 1);
      check("bp_second_data", bus.data_o, 32'h0F);

      idle(1);
      step(1, 1, OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 1);
      idle(9);
      step(0, 0, OP_PASS, '0, '0, 1);
      check("midrst_data", bus.data_o, 0);
      check("midrst_valid", bus.out_valid_o, 0);
      check("midrst_busy", bus.busy_o, 0);
      check("midrst_ready", bus.in_ready_o, 1);
      idle(40);
      step(1, 1, OP_SUM, 32'h1, 32'h1, 1);
      check("post_rst_sum", bus.data_o, 32'h2);

      step(1, 1, OP_P7, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
      check("pass7_data", bus.data_o, 32'hDEAD_BEEF);
      check("pass7_zero", bus.Zero_o, 1);

      for (int i = 0; i < 600; i++) begin
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
         step(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0),
              3'($urandom_range(0, 7)), ra, rb, ($urandom_range(0, 3) != 0));
      end
      idle(40);

      mul4(32'h0001_0003, 32'h0002_0005);
      for (int i = 0; i < 4; i++) begin
         ra = $urandom;
         mul4(ra, (i == 0) ? ra : $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
